// File: rtl/rsp_frame_tx_pkg.sv
// Shared constants for the response-frame transmitter: frame delimiters,
// byte type, FSM state and frame phase encodings.
package rsp_frame_tx_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef logic [7:0] data_t;

  localparam data_t START_CMD = 8'hFE;
  localparam data_t END_CMD   = 8'hEF;

  localparam int unsigned ST_W = 3;
  localparam int unsigned PH_W = 3;

  // Main FSM states
  localparam logic [ST_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [ST_W-1:0] ST_SELECT    = 3'd1;
  localparam logic [ST_W-1:0] ST_FETCH     = 3'd2;
  localparam logic [ST_W-1:0] ST_CAPTURE   = 3'd3;
  localparam logic [ST_W-1:0] ST_KICK      = 3'd4;
  localparam logic [ST_W-1:0] ST_WAIT_ACK  = 3'd5;
  localparam logic [ST_W-1:0] ST_WAIT_DONE = 3'd6;

  // Frame phases, in transmission order
  localparam logic [PH_W-1:0] PH_SOF     = 3'd0;
  localparam logic [PH_W-1:0] PH_LEN     = 3'd1;
  localparam logic [PH_W-1:0] PH_CMD     = 3'd2;
  localparam logic [PH_W-1:0] PH_PAYLOAD = 3'd3;
  localparam logic [PH_W-1:0] PH_CSUM    = 3'd4;
  localparam logic [PH_W-1:0] PH_EOF     = 3'd5;

endpackage

// File: rtl/rsp_frame_tx.sv
// Response-frame transmitter: serialises FE, LEN, CMD, payload, [CSUM], EF
// into a UART transmitter using a start/busy handshake.
// Optional feature macro: RSP_CHECKSUM_EN adds an XOR checksum byte before EF.
module rsp_frame_tx
  import rsp_frame_tx_pkg::*;
#(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1),
  parameter int unsigned ADDR_W  = $clog2(MAX_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              send,
  input  logic [7:0]        rsp_cmd,
  input  logic [LEN_W-1:0]  rsp_len,
  output logic              busy,
  output logic              done,
  output logic              pl_rd_en,
  output logic [ADDR_W-1:0] pl_rd_addr,
  input  logic [7:0]        pl_rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy
);

`ifdef RSP_CHECKSUM_EN
  localparam logic [PH_W-1:0] PH_AFTER_PL = PH_CSUM;
`else
  localparam logic [PH_W-1:0] PH_AFTER_PL = PH_EOF;
`endif

  logic [ST_W-1:0]   state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0]  len_q, len_d;
  data_t             cmd_q, cmd_d;
  data_t             tx_data_d;
  logic              busy_d, done_d, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_d;
`ifdef RSP_CHECKSUM_EN
  data_t             csum_q, csum_d;
`endif

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      phase_q    <= PH_SOF;
      idx_q      <= '0;
      len_q      <= '0;
      cmd_q      <= '0;
      tx_data    <= '0;
      busy       <= FALSE;
      done       <= FALSE;
      pl_rd_en   <= FALSE;
      pl_rd_addr <= '0;
`ifdef RSP_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      cmd_q      <= cmd_d;
      tx_data    <= tx_data_d;
      busy       <= busy_d;
      done       <= done_d;
      pl_rd_en   <= rd_en_d;
      pl_rd_addr <= rd_addr_d;
`ifdef RSP_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  // Next-state, byte selection and handshake decode
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    idx_d     = idx_q;
    len_d     = len_q;
    cmd_d     = cmd_q;
    tx_data_d = tx_data;
    busy_d    = busy;
    done_d    = FALSE;
    rd_en_d   = FALSE;
    rd_addr_d = pl_rd_addr;
    tx_start  = FALSE;
`ifdef RSP_CHECKSUM_EN
    csum_d    = csum_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // The done cycle itself does not accept a new request
        if (send && !done) begin
          cmd_d   = rsp_cmd;
          len_d   = (rsp_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : rsp_len;
          idx_d   = '0;
          phase_d = PH_SOF;
          busy_d  = TRUE;
          state_d = ST_SELECT;
`ifdef RSP_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end

      ST_SELECT: begin
        state_d = ST_KICK;
        case (phase_q)
          PH_SOF: tx_data_d = START_CMD;
          PH_LEN: begin
            tx_data_d = 8'(len_q);
`ifdef RSP_CHECKSUM_EN
            csum_d    = csum_q ^ 8'(len_q);
`endif
          end
          PH_CMD: begin
            tx_data_d = cmd_q;
`ifdef RSP_CHECKSUM_EN
            csum_d    = csum_q ^ cmd_q;
`endif
          end
          PH_PAYLOAD: begin
            rd_en_d   = TRUE;
            rd_addr_d = idx_q;
            state_d   = ST_FETCH;
          end
`ifdef RSP_CHECKSUM_EN
          PH_CSUM: tx_data_d = csum_q;
`endif
          default: tx_data_d = END_CMD;
        endcase
      end

      ST_FETCH: state_d = ST_CAPTURE;

      ST_CAPTURE: begin
        tx_data_d = pl_rd_data;
`ifdef RSP_CHECKSUM_EN
        csum_d    = csum_q ^ pl_rd_data;
`endif
        state_d   = ST_KICK;
      end

      ST_KICK: begin
        if (!tx_busy) begin
          tx_start = TRUE;
          state_d  = ST_WAIT_ACK;
        end
      end

      ST_WAIT_ACK: begin
        if (tx_busy) state_d = ST_WAIT_DONE;
      end

      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = ST_SELECT;
          case (phase_q)
            PH_SOF: phase_d = PH_LEN;
            PH_LEN: phase_d = PH_CMD;
            PH_CMD: phase_d = (len_q == '0) ? PH_AFTER_PL : PH_PAYLOAD;
            PH_PAYLOAD: begin
              if (LEN_W'(idx_q) + LEN_W'(1) == len_q) phase_d = PH_AFTER_PL;
              else idx_d = idx_q + ADDR_W'(1);
            end
`ifdef RSP_CHECKSUM_EN
            PH_CSUM: phase_d = PH_EOF;
`endif
            default: begin
              done_d  = TRUE;
              busy_d  = FALSE;
              phase_d = PH_SOF;
              state_d = ST_IDLE;
            end
          endcase
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule
